// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, single-outstanding instruction fetch, one-entry stall buffer, redirect flush.
// Optional macro FETCH_ACCESS_FAULT_EN adds iresp_err and INSTRUCTION_ACCESS_FAULT records.
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic         clk,
   input  logic         rst,
   output logic         ireq_valid,
   output logic [63:0]  ireq_addr,
   input  logic         iresp_data_ok,
   input  logic [31:0]  iresp_data,
`ifdef FETCH_ACCESS_FAULT_EN
   input  logic         iresp_err,
`endif
   input  logic         JumpEn,
   input  logic [63:0]  jumpAddr,
   output logic         ok_to_proceed,
   input  logic         ok_to_proceed_overall,
   // REG_IF_ID: {valid, pc, pcPlus4, instr, instrAddr, exception_valid, exception[3:0]}
   output logic [229:0] moduleOut
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_READY = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
   localparam logic [3:0] EXC_INSTR_ACCESS     = 4'd1;
   localparam logic [3:0] EXC_NONE             = 4'd15;

   logic [1:0]  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] req_addr_q, req_addr_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic        buf_err_q, buf_err_d;

   logic        out_valid_q, out_valid_d;
   logic [63:0] out_pc_q, out_pc_d;
   logic [63:0] out_pc4_q, out_pc4_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic        out_exc_valid_q, out_exc_valid_d;
   logic [3:0]  out_exc_q, out_exc_d;

   logic        misaligned;
   logic        redirect;
   logic        resp_err;
   logic        do_emit;
   logic [31:0] emit_instr;
   logic        emit_exc_valid;
   logic [3:0]  emit_exc;

`ifdef FETCH_ACCESS_FAULT_EN
   assign resp_err = iresp_err;
`else
   assign resp_err = 1'b0;
`endif

   assign misaligned = (pc_q[1:0] != 2'b00);
   assign redirect   = JumpEn & ok_to_proceed_overall;

   assign moduleOut = {out_valid_q, out_pc_q, out_pc4_q, out_instr_q, out_pc_q,
                       out_exc_valid_q, out_exc_q};

   // Bus outputs depend only on registered state, never on iresp_*.
   always_comb begin
      ireq_valid    = 1'b0;
      ireq_addr     = pc_q;
      ok_to_proceed = 1'b0;
      case (state_q)
         ST_FETCH: begin
            ireq_valid    = ~misaligned;
            ok_to_proceed = iresp_data_ok | JumpEn | misaligned;
         end
         ST_READY: ok_to_proceed = 1'b1;
         ST_FLUSH: begin
            ireq_valid    = 1'b1;
            ireq_addr     = req_addr_q;
            ok_to_proceed = JumpEn;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      req_addr_d      = req_addr_q;
      buf_instr_d     = buf_instr_q;
      buf_err_d       = buf_err_q;
      out_valid_d     = out_valid_q;
      out_pc_d        = out_pc_q;
      out_pc4_d       = out_pc4_q;
      out_instr_d     = out_instr_q;
      out_exc_valid_d = out_exc_valid_q;
      out_exc_d       = out_exc_q;
      do_emit         = 1'b0;
      emit_instr      = 32'd0;
      emit_exc_valid  = 1'b0;
      emit_exc        = EXC_NONE;

      case (state_q)
         ST_FETCH: begin
            // A misaligned pc never issued a request, so a redirect here has nothing to flush.
            if (misaligned) begin
               do_emit        = ok_to_proceed_overall;
               emit_exc_valid = 1'b1;
               emit_exc       = EXC_INSTR_MISALIGNED;
            end else if (iresp_data_ok) begin
               if (ok_to_proceed_overall) begin
                  do_emit        = 1'b1;
                  emit_instr     = resp_err ? 32'd0 : iresp_data;
                  emit_exc_valid = resp_err;
                  emit_exc       = resp_err ? EXC_INSTR_ACCESS : EXC_NONE;
               end else begin
                  buf_instr_d = iresp_data;
                  buf_err_d   = resp_err;
                  state_d     = ST_READY;
               end
            end else if (redirect) begin
               req_addr_d = pc_q;
               state_d    = ST_FLUSH;
            end
         end
         ST_READY: begin
            if (ok_to_proceed_overall) begin
               do_emit        = 1'b1;
               emit_instr     = buf_err_q ? 32'd0 : buf_instr_q;
               emit_exc_valid = buf_err_q;
               emit_exc       = buf_err_q ? EXC_INSTR_ACCESS : EXC_NONE;
               state_d        = ST_FETCH;
            end
         end
         ST_FLUSH: begin
            if (iresp_data_ok) state_d = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase

      if (redirect) begin
         pc_d            = jumpAddr;
         out_valid_d     = 1'b0;
         out_exc_valid_d = 1'b0;
      end else if (do_emit) begin
         out_valid_d     = 1'b1;
         out_pc_d        = pc_q;
         out_pc4_d       = pc_q + 64'd4;
         out_instr_d     = emit_instr;
         out_exc_valid_d = emit_exc_valid;
         out_exc_d       = emit_exc;
         pc_d            = pc_q + 64'd4;
      end else if (ok_to_proceed_overall) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= ST_FETCH;
         pc_q            <= RESET_PC;
         req_addr_q      <= RESET_PC;
         buf_instr_q     <= 32'd0;
         buf_err_q       <= 1'b0;
         out_valid_q     <= 1'b0;
         out_pc_q        <= 64'd0;
         out_pc4_q       <= 64'd0;
         out_instr_q     <= 32'd0;
         out_exc_valid_q <= 1'b0;
         out_exc_q       <= EXC_NONE;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         req_addr_q      <= req_addr_d;
         buf_instr_q     <= buf_instr_d;
         buf_err_q       <= buf_err_d;
         out_valid_q     <= out_valid_d;
         out_pc_q        <= out_pc_d;
         out_pc4_q       <= out_pc4_d;
         out_instr_q     <= out_instr_d;
         out_exc_valid_q <= out_exc_valid_d;
         out_exc_q       <= out_exc_d;
      end
   end

endmodule
